// File: rtl/fpu_pkg.sv
// Shared FP constants and types for the divide/sqrt issue path.
package fpu_pkg;
  localparam int FP_EXPWIDTH = 8;
  localparam int FP_SIGWIDTH = 24;

  // IEEE rounding-mode encodings
  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  // Bit positions inside the 5-bit {NV,DZ,OF,UF,NX} flag word
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } div_state_e;
endpackage

// File: rtl/fdivsqrt_issue_if.sv
// Request / divider-launch / writeback bundle around the div-sqrt sequencer.
// master: the sequencer. slave: issue stage, divider and writeback consumer.
interface fdivsqrt_issue_if import fpu_pkg::*; #(
  parameter int EXPWIDTH = FP_EXPWIDTH,
  parameter int SIGWIDTH = FP_SIGWIDTH,
  parameter int TAGWIDTH = 4
);
  localparam int W = EXPWIDTH + SIGWIDTH;

  logic                req_valid;
  logic                req_ready;
  logic [W-1:0]        req_frs1;
  logic [W-1:0]        req_frs2;
  logic                req_ftype;
  logic [2:0]          req_rm;
  logic [TAGWIDTH-1:0] req_tag;

  logic                div_valid_in;
  logic                div_ready;
  logic [W-1:0]        div_frs1;
  logic [W-1:0]        div_frs2;
  logic                div_ftype;
  logic [2:0]          div_rm;
  logic                div_finish;
  logic [W-1:0]        div_res;
  logic [4:0]          div_flags;

  logic                wb_valid;
  logic                wb_ready;
  logic [W-1:0]        wb_res;
  logic [4:0]          wb_flags;
  logic [TAGWIDTH-1:0] wb_tag;

  modport master (
    input  req_valid, req_frs1, req_frs2, req_ftype, req_rm, req_tag,
    output req_ready,
    output div_valid_in, div_frs1, div_frs2, div_ftype, div_rm,
    input  div_ready, div_finish, div_res, div_flags,
    output wb_valid, wb_res, wb_flags, wb_tag,
    input  wb_ready
  );

  modport slave (
    output req_valid, req_frs1, req_frs2, req_ftype, req_rm, req_tag,
    input  req_ready,
    input  div_valid_in, div_frs1, div_frs2, div_ftype, div_rm,
    output div_ready, div_finish, div_res, div_flags,
    input  wb_valid, wb_res, wb_flags, wb_tag,
    output wb_ready
  );
endinterface

// File: rtl/fdivsqrt_req_fifo.sv
// Small sync FIFO holding packed div/sqrt requests; flush empties it.
module fdivsqrt_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // Wrap bit distinguishes full from empty when the index bits match.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer update; flush wins over push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; cleared on reset so the head never shows stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end
endmodule

// File: rtl/fdivsqrt_issue.sv
// Div/sqrt request buffer and sequencer: queues requests, launches one at a
// time into the iterative divider, and holds each result for writeback.
module fdivsqrt_issue import fpu_pkg::*; #(
  parameter int EXPWIDTH = FP_EXPWIDTH,
  parameter int SIGWIDTH = FP_SIGWIDTH,
  parameter int DEPTH    = 4,
  parameter int TAGWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  fdivsqrt_issue_if.master  io,
  output logic              busy
);
  localparam int W  = EXPWIDTH + SIGWIDTH;
  localparam int PW = 2*W + 1 + 3 + TAGWIDTH;

  logic [PW-1:0]       fifo_din, fifo_dout;
  logic                fifo_full, fifo_empty;
  logic                push, launch, capture;
  logic [W-1:0]        head_frs1, head_frs2;
  logic                head_ftype;
  logic [2:0]          head_rm;
  logic [TAGWIDTH-1:0] head_tag;

  div_state_e          state_q, state_d;
  logic                kill_q, kill_d;
  logic [TAGWIDTH-1:0] inflight_tag_q;
  logic [W-1:0]        wb_res_q;
  logic [4:0]          wb_flags_q;
  logic [TAGWIDTH-1:0] wb_tag_q;

  assign fifo_din = {io.req_frs1, io.req_frs2, io.req_ftype, io.req_rm, io.req_tag};
  assign {head_frs1, head_frs2, head_ftype, head_rm, head_tag} = fifo_dout;

  // Ready comes from registered pointers only, so a same-cycle launch
  // never opens a slot for a push.
  assign io.req_ready = !fifo_full;
  assign push         = io.req_valid && io.req_ready;

  assign io.div_valid_in = (state_q == IDLE) && !fifo_empty && !flush;
  assign io.div_frs1     = head_frs1;
  assign io.div_frs2     = head_frs2;
  assign io.div_ftype    = head_ftype;
  assign io.div_rm       = head_rm;
  assign launch          = io.div_valid_in && io.div_ready;

  fdivsqrt_req_fifo #(
    .WIDTH (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (launch),
    .flush (flush),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next state: flush kills the in-flight op or drops a held result.
  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: if (launch) state_d = WAIT;
      WAIT: begin
        if (io.div_finish) begin
          kill_d = 1'b0;
          if (kill_q || flush) begin
            state_d = IDLE;
          end else begin
            state_d = HOLD;
            capture = 1'b1;
          end
        end else if (flush) begin
          kill_d = 1'b1;
        end
      end
      HOLD: if (flush || io.wb_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, kill bit and tag of the op currently in the divider.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      kill_q         <= 1'b0;
      inflight_tag_q <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      if (launch) inflight_tag_q <= head_tag;
    end
  end

  // Writeback registers load on a live finish and stay put while held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_res_q   <= '0;
      wb_flags_q <= '0;
      wb_tag_q   <= '0;
    end else if (capture) begin
      wb_res_q   <= io.div_res;
      wb_flags_q <= io.div_flags;
      wb_tag_q   <= inflight_tag_q;
    end
  end

  assign io.wb_valid = (state_q == HOLD);
  assign io.wb_res   = wb_res_q;
  assign io.wb_flags = wb_flags_q;
  assign io.wb_tag   = wb_tag_q;
  assign busy        = !fifo_empty || (state_q != IDLE);
endmodule

// File: tb/tb_fdivsqrt_issue.sv
// Directed bench for fdivsqrt_issue: queue-based reference model compared
// every cycle, plus literal checks on hand-computed results.
module tb_fdivsqrt_issue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic busy;

  fdivsqrt_issue_if #(.EXPWIDTH(8), .SIGWIDTH(24), .TAGWIDTH(4)) io();

  fdivsqrt_issue #(.EXPWIDTH(8), .SIGWIDTH(24), .DEPTH(DEPTH), .TAGWIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .io    (io),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Hand-computed IEEE single results for the operands this bench uses.
  function automatic logic [36:0] fake_div(input logic [31:0] a, input logic [31:0] b, input logic ft);
    case ({ft, a, b})
      {1'b0, 32'h40400000, 32'h3F800000}: return {32'h40400000, 5'b00000}; // 3/1
      {1'b0, 32'h40C00000, 32'h40000000}: return {32'h40400000, 5'b00000}; // 6/2
      {1'b0, 32'h3F800000, 32'h00000000}: return {32'h7F800000, 5'b01000}; // 1/0
      {1'b0, 32'h3F800000, 32'h40400000}: return {32'h3EAAAAAB, 5'b00001}; // 1/3
      {1'b1, 32'hBF800000, 32'h00000000}: return {32'h7FC00000, 5'b10000}; // sqrt(-1)
      {1'b1, 32'h40800000, 32'h00000000}: return {32'h40000000, 5'b00000}; // sqrt(4)
      default: return {a ^ b, 5'b00001};
    endcase
  endfunction

  // ---------------- divider stub ----------------
  logic        launch_s = 1'b0;
  logic [36:0] pend_s   = '0;
  logic [36:0] pend     = '0;
  int          cnt      = 0;
  int          lat      = 3;
  bit          spur     = 1'b0;

  always @(negedge clk) begin
    launch_s = io.div_valid_in && io.div_ready;
    pend_s   = fake_div(io.div_frs1, io.div_frs2, io.div_ftype);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           = 0;
      io.div_finish = 1'b0;
      io.div_res    = '0;
      io.div_flags  = '0;
    end else begin
      #2;
      io.div_finish = 1'b0;
      if (cnt == 1) begin
        io.div_finish = 1'b1;
        {io.div_res, io.div_flags} = pend;
      end else if (spur) begin
        io.div_finish = 1'b1;
        {io.div_res, io.div_flags} = {32'hDEADBEEF, 5'b11111};
      end
      if (cnt > 0) cnt--;
      if (launch_s) begin
        cnt  = lat;
        pend = pend_s;
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        ft;
    logic [2:0]  rm;
    logic [3:0]  tag;
  } req_t;

  req_t        mq[$];
  bit          m_div, m_kill, m_hold;
  logic [31:0] m_res;
  logic [4:0]  m_flags;
  logic [3:0]  m_tag, m_iftag;

  function automatic bit exp_dvi();
    return !m_div && !m_hold && (mq.size() > 0) && !flush;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_div = 0; m_kill = 0; m_hold = 0;
      m_res = '0; m_flags = '0; m_tag = '0; m_iftag = '0;
    end else begin : upd
      bit   go, take;
      req_t r;
      go   = exp_dvi() && io.div_ready;
      take = io.req_valid && (mq.size() < DEPTH) && !flush;
      if (m_div) begin
        if (io.div_finish) begin
          m_div = 0;
          if (!m_kill && !flush) begin
            m_hold = 1; m_res = io.div_res; m_flags = io.div_flags; m_tag = m_iftag;
          end
          m_kill = 0;
        end else if (flush) begin
          m_kill = 1;
        end
      end else if (m_hold) begin
        if (flush || io.wb_ready) m_hold = 0;
      end else if (go) begin
        m_iftag = mq[0].tag;
        void'(mq.pop_front());
        m_div = 1;
      end
      if (flush) mq.delete();
      if (take) begin
        r.a = io.req_frs1; r.b = io.req_frs2; r.ft = io.req_ftype;
        r.rm = io.req_rm; r.tag = io.req_tag;
        mq.push_back(r);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst) begin
      chk("req_ready", io.req_ready, mq.size() < DEPTH);
      chk("div_valid_in", io.div_valid_in, exp_dvi());
      if (exp_dvi()) begin
        chk("div_frs1", io.div_frs1, mq[0].a);
        chk("div_frs2", io.div_frs2, mq[0].b);
        chk("div_ftype", io.div_ftype, mq[0].ft);
        chk("div_rm", io.div_rm, mq[0].rm);
      end
      chk("wb_valid", io.wb_valid, m_hold);
      chk("wb_res", io.wb_res, m_res);
      chk("wb_flags", io.wb_flags, m_flags);
      chk("wb_tag", io.wb_tag, m_tag);
      chk("busy", busy, (mq.size() > 0) || m_div || m_hold);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic [31:0] a, input logic [31:0] b, input logic ft,
                          input logic [2:0] rm, input logic [3:0] tag);
    bit acc;
    int g;
    acc = 0; g = 0;
    io.req_valid = 1'b1; io.req_frs1 = a; io.req_frs2 = b;
    io.req_ftype = ft; io.req_rm = rm; io.req_tag = tag;
    while (!acc && g < 100) begin
      @(negedge clk);
      acc = io.req_ready && !flush;
      @(posedge clk);
      #1;
      g++;
    end
    io.req_valid = 1'b0;
    chk($sformatf("push_tag%0d", tag), acc, 1);
  endtask

  task automatic see_wb(input logic [31:0] res, input logic [4:0] fl, input logic [3:0] tag);
    bit seen;
    int g;
    seen = 0; g = 0;
    while (!seen && g < 200) begin
      @(negedge clk);
      seen = io.wb_valid;
      g++;
    end
    chk($sformatf("wb_seen_tag%0d", tag), seen, 1);
    chk($sformatf("wb_res_lit_tag%0d", tag), io.wb_res, res);
    chk($sformatf("wb_flags_lit_tag%0d", tag), io.wb_flags, fl);
    chk("wb_tag_lit", io.wb_tag, tag);
  endtask

  task automatic accept_wb(input int hold);
    tick(1);
    if (hold > 0) tick(hold);
    io.wb_ready = 1'b1;
    tick(1);
    io.wb_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    bit wb_seen, dropped;
    rst = 1'b0; flush = 1'b0;
    io.req_valid = 1'b0; io.req_frs1 = '0; io.req_frs2 = '0;
    io.req_ftype = 1'b0; io.req_rm = '0; io.req_tag = '0;
    io.div_ready = 1'b1; io.wb_ready = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_req_ready", io.req_ready, 1);
    chk("rst_div_valid", io.div_valid_in, 0);
    chk("rst_wb_valid", io.wb_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wb_res", io.wb_res, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick(1);

    // 1: single divide 3.0/1.0, launch one cycle after accept
    push_req(32'h40400000, 32'h3F800000, 1'b0, 3'd0, 4'd3);
    chk("t1_launch", io.div_valid_in, 1);
    chk("t1_frs1", io.div_frs1, 32'h40400000);
    chk("t1_frs2", io.div_frs2, 32'h3F800000);
    see_wb(32'h40400000, 5'b00000, 4'd3);
    accept_wb(5);

    // 2: fill FIFO with divider stalled, then drain in order
    io.div_ready = 1'b0;
    push_req(32'h40C00000, 32'h40000000, 1'b0, 3'd1, 4'd0);
    push_req(32'h3F800000, 32'h00000000, 1'b0, 3'd2, 4'd1);
    push_req(32'h3F800000, 32'h40400000, 1'b0, 3'd3, 4'd2);
    push_req(32'h40800000, 32'h00000000, 1'b1, 3'd4, 4'd3);
    chk("t2_full", io.req_ready, 0);
    io.req_valid = 1'b1; io.req_tag = 4'd4;
    io.req_frs1 = 32'h40C00000; io.req_frs2 = 32'h40000000; io.req_ftype = 1'b0;
    tick(3);
    chk("t2_still_full", io.req_ready, 0);
    io.div_ready = 1'b1;
    push_req(32'h40C00000, 32'h40000000, 1'b0, 3'd0, 4'd4);
    see_wb(32'h40400000, 5'b00000, 4'd0); accept_wb(0);
    see_wb(32'h7F800000, 5'b01000, 4'd1); accept_wb(0);
    see_wb(32'h3EAAAAAB, 5'b00001, 4'd2); accept_wb(0);
    see_wb(32'h40000000, 5'b00000, 4'd3); accept_wb(0);
    see_wb(32'h40400000, 5'b00000, 4'd4); accept_wb(0);

    // 3: sqrt(-1) -> default NaN with NV
    push_req(32'hBF800000, 32'h00000000, 1'b1, 3'd0, 4'd5);
    chk("t3_launch", io.div_valid_in, 1);
    chk("t3_ftype", io.div_ftype, 1);
    see_wb(32'h7FC00000, 5'b10000, 4'd5);
    accept_wb(2);

    // 4: long hold blocks the next launch
    push_req(32'h40400000, 32'h3F800000, 1'b0, 3'd0, 4'd6);
    see_wb(32'h40400000, 5'b00000, 4'd6);
    tick(1);
    push_req(32'h40C00000, 32'h40000000, 1'b0, 3'd0, 4'd7);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("t4_no_launch", io.div_valid_in, 0);
      chk("t4_hold_tag", io.wb_tag, 4'd6);
    end
    io.wb_ready = 1'b1;
    tick(1);
    io.wb_ready = 1'b0;
    chk("t4_released", io.wb_valid, 0);
    chk("t4_relaunch", io.div_valid_in, 1);
    tick(1);
    chk("t4_waiting", io.div_valid_in, 0);
    see_wb(32'h40400000, 5'b00000, 4'd7);
    accept_wb(0);

    // 5: flush in WAIT with two queued; same-cycle push ignored
    lat = 8;
    push_req(32'h40400000, 32'h3F800000, 1'b0, 3'd0, 4'd8);
    push_req(32'h3F800000, 32'h40400000, 1'b0, 3'd0, 4'd9);
    push_req(32'h40C00000, 32'h40000000, 1'b0, 3'd0, 4'd10);
    chk("t5_busy_pre", busy, 1);
    flush = 1'b1; io.req_valid = 1'b1; io.req_tag = 4'd12;
    tick(1);
    flush = 1'b0; io.req_valid = 1'b0;
    chk("t5_fifo_empty", io.req_ready, 1);
    chk("t5_no_launch", io.div_valid_in, 0);
    chk("t5_busy_wait", busy, 1);
    wb_seen = 0; dropped = 0;
    for (int i = 0; i < 50 && !dropped; i++) begin
      @(negedge clk);
      if (io.wb_valid) wb_seen = 1;
      dropped = !busy;
    end
    chk("t5_busy_dropped", dropped, 1);
    chk("t5_no_wb", wb_seen, 0);
    tick(1);
    spur = 1'b1;
    tick(1);
    spur = 1'b0;
    tick(2);
    chk("t5_spur_ignored", io.wb_valid, 0);
    lat = 3;
    push_req(32'h3F800000, 32'h00000000, 1'b0, 3'd0, 4'd11);
    see_wb(32'h7F800000, 5'b01000, 4'd11);
    accept_wb(0);

    // 6: async reset in the middle of WAIT
    lat = 6;
    push_req(32'h40400000, 32'h3F800000, 1'b0, 3'd0, 4'd13);
    tick(2);
    #2 rst = 1'b1;
    #1;
    chk("t6_req_ready", io.req_ready, 1);
    chk("t6_div_valid", io.div_valid_in, 0);
    chk("t6_wb_valid", io.wb_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_wb_res", io.wb_res, 0);
    chk("t6_wb_tag", io.wb_tag, 0);
    chk("t6_wb_flags", io.wb_flags, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick(10);
    chk("t6_no_wb", io.wb_valid, 0);
    lat = 3;
    push_req(32'h40800000, 32'h00000000, 1'b1, 3'd0, 4'd14);
    see_wb(32'h40000000, 5'b00000, 4'd14);
    accept_wb(0);

    // flush while holding a result drops it
    push_req(32'h40400000, 32'h3F800000, 1'b0, 3'd0, 4'd15);
    see_wb(32'h40400000, 5'b00000, 4'd15);
    tick(1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    chk("t7_hold_flushed", io.wb_valid, 0);
    chk("t7_idle", busy, 0);
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fdivsqrt_issue.md
Name: fdivsqrt_issue

Overview:
Request buffer and sequencer that sits directly upstream of the iterative divide/sqrt unit. It accepts div/sqrt requests from the FP issue stage into a small FIFO and launches them one at a time into the divider using its valid_in/ready_out handshake. It waits for the divider's one-cycle finish pulse, latches the result and flags, and holds them on a tagged writeback port until the consumer accepts them.

Parameters:
EXPWIDTH, 8, exponent width of IEEE operands
SIGWIDTH, 24, significand width including hidden bit (IEEE word = EXPWIDTH+SIGWIDTH)
DEPTH, 4, request FIFO entries (power of 2, >=2)
TAGWIDTH, 4, destination/ROB tag width carried alongside each request

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush  in  1  kill all queued and in-flight requests
req_valid  in  1  request offered
req_ready  out  1  FIFO can accept
req_frs1  in  EXPWIDTH+SIGWIDTH  dividend / sqrt operand
req_frs2  in  EXPWIDTH+SIGWIDTH  divisor (ignored for sqrt)
req_ftype  in  1  1=sqrt, 0=div
req_rm  in  3  rounding mode
req_tag  in  TAGWIDTH  writeback tag
div_valid_in  out  1  launch to divider
div_ready  in  1  divider inReady
div_frs1  out  EXPWIDTH+SIGWIDTH  operand a
div_frs2  out  EXPWIDTH+SIGWIDTH  operand b
div_ftype  out  1  sqrt select
div_rm  out  3  rounding mode
div_finish  in  1  divider result-valid pulse
div_res  in  EXPWIDTH+SIGWIDTH  divider result (IEEE)
div_flags  in  5  divider exception flags
wb_valid  out  1  result available
wb_ready  in  1  consumer accepts
wb_res  out  EXPWIDTH+SIGWIDTH  result
wb_flags  out  5  exception flags {NV,DZ,OF,UF,NX}
wb_tag  out  TAGWIDTH  tag of result
busy  out  1  FIFO non-empty or state != IDLE

Behaviour:
- Reset (async, rst=1): FIFO empty, pointers 0, state IDLE, req_ready=1, div_valid_in=0, wb_valid=0, wb_res/wb_flags/wb_tag=0, busy=0. Reset mid-operation abandons everything; a later div_finish from the old op is dropped, since the divider shares rst.
- FIFO: push when req_valid&&req_ready. req_ready = !full, registered-count based. A pop in the same cycle does not free a slot for a push that cycle. Pointers are log2(DEPTH)+1 bits with wrap bit. Full = MSBs differ and LSBs equal.
- Launch outputs div_frs1/div_frs2/div_ftype/div_rm are driven combinationally from the FIFO head. div_valid_in is combinational: state==IDLE && !empty && !flush. Launch fires when div_valid_in && div_ready. On launch: pop head, latch head tag into inflight_tag, state->WAIT.
- Minimum latency: request accepted in cycle N, earliest div_valid_in in N+1 (no bypass).
- State machine:
  - IDLE: launch -> WAIT.
  - WAIT: div_finish -> capture div_res/div_flags/inflight_tag into wb registers, wb_valid=1 next cycle, state->HOLD. If the kill bit is set, discard the result and go to IDLE with wb_valid staying 0.
  - HOLD: wb_valid=1, outputs stable. wb_valid&&wb_ready -> wb_valid=0, state->IDLE. A launch may occur in the next cycle at the earliest.
- Flush:
  - Empties the FIFO next cycle; a push in the same cycle is ignored.
  - In WAIT, sets the kill bit so the pending finish is swallowed.
  - In HOLD, clears wb_valid and goes to IDLE.
  - Flush has priority over push, launch, and writeback.
- div_finish outside WAIT is ignored.
- busy = !empty || state!=IDLE.

Decomposition:
- Shared package fpu_pkg: IEEE width constants (EXPWIDTH/SIGWIDTH defaults), rounding-mode encodings, flag bit positions, state enum {IDLE, WAIT, HOLD}.
- One sub-module: fdivsqrt_req_fifo, a parameterised sync FIFO with push/pop/flush, full/empty, head data. The payload is the packed {frs1, frs2, ftype, rm, tag}.

Test Plan:
1. Single div 0x40400000/0x3F800000, rm=0, tag=3, div_ready=1 -> div_valid_in one cycle later with those operands; after finish, wb_res=0x40400000, wb_flags=0, wb_tag=3, held until wb_ready.
2. Push 4 requests back-to-back (tags 0..3) with divider stalled -> req_ready=0 after 4th push; 5th req_valid not accepted. Results return in order with tags 0,1,2,3.
3. sqrt of 0xBF800000 (-1.0) -> wb_res=0x7FC00000, wb_flags=5'b10000 (NV), div_ftype=1 at launch.
4. wb_ready held low 20 cycles in HOLD -> wb outputs stable, no new div_valid_in. wb_ready=1 -> next cycle IDLE, next request launches the following cycle.
5. flush asserted in WAIT with 2 queued -> FIFO empty, busy drops once finish arrives, wb_valid never asserts for that op, new request afterwards completes normally.
6. rst pulsed mid-WAIT asynchronously (between clock edges) -> all outputs at reset values immediately, req_ready=1, no writeback of the aborted op.
